// File: rtl/cic_decim_front_pkg.sv
// Shared constants and FSM encoding for the CIC decimator front end.
// The module parameters are fixed here so every file of the slice agrees on them.
package cic_pkg;

    localparam int unsigned DW_IN  = 16;
    localparam int unsigned DW_OUT = 12;
    localparam int unsigned N      = 4;
    localparam int unsigned R      = 625;
    localparam int unsigned ACC_W  = 54;
    localparam int unsigned SHIFT  = ACC_W - DW_OUT;

    // Half an output LSB, added before the arithmetic shift (round half up)
    localparam logic [ACC_W-1:0] ROUND_K =
        {{(ACC_W - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    localparam logic signed [DW_OUT-1:0] OUT_MAX = {1'b0, {(DW_OUT - 1){1'b1}}};
    localparam logic signed [DW_OUT-1:0] OUT_MIN = {1'b1, {(DW_OUT - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COMB  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } cic_state_e;

endpackage

// File: rtl/cic_decim_front_if.sv
// Sample-stream interface between the ADC-side source and the CIC decimator.
// The decimated side (filter_out/ce_out) feeds the compensation FIR.
interface cic_decim_front_if;
    import cic_pkg::*;

    logic                     in_valid;
    logic signed [DW_IN-1:0]  filter_in;
    logic signed [DW_OUT-1:0] filter_out;
    logic                     ce_out;

    modport master (
        output in_valid,
        output filter_in,
        input  filter_out,
        input  ce_out
    );

    modport slave (
        input  in_valid,
        input  filter_in,
        output filter_out,
        output ce_out
    );

endinterface

// File: rtl/cic_decim_front_comb_engine.sv
// Comb section of the CIC decimator: N combs share one subtractor, stepped by a
// small FSM, followed by round-half-up, saturation and the output register.
module cic_comb_engine
    import cic_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_c,
    input  logic signed [ACC_W-1:0]  snap_c,
    output logic signed [DW_OUT-1:0] filter_out,
    output logic                     ce_out
);

    localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;

    cic_state_e state;
    cic_state_e state_d;

    logic                     start_q;
    logic signed [ACC_W-1:0]  snap;
    logic signed [ACC_W-1:0]  x;
    logic signed [ACC_W-1:0]  x_d;
    logic signed [ACC_W-1:0]  cd   [N];
    logic signed [ACC_W-1:0]  cd_d [N];
    logic [K_W-1:0]           k;
    logic [K_W-1:0]           k_d;
    logic signed [DW_OUT-1:0] r;
    logic signed [DW_OUT-1:0] r_d;
    logic signed [DW_OUT-1:0] out_d;
    logic                     ce_d;

    logic [ACC_W:0]           sum_c;
    logic [DW_OUT:0]          rfull_c;
    logic signed [DW_OUT-1:0] rnd_c;

    // Capture the decimated integrator value; the FSM picks it up one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            snap    <= '0;
        end else begin
            start_q <= start_c;
            if (start_c) begin
                snap <= snap_c;
            end
        end
    end

    // One extra guard bit absorbs the carry of the rounding add
    always_comb begin
        sum_c   = {x[ACC_W-1], x} + {1'b0, ROUND_K};
        rfull_c = (DW_OUT + 1)'(sum_c >> SHIFT);
        rnd_c   = rfull_c[DW_OUT-1:0];
        if (rfull_c[DW_OUT] != rfull_c[DW_OUT-1]) begin
            rnd_c = rfull_c[DW_OUT] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        x_d     = x;
        cd_d    = cd;
        k_d     = k;
        r_d     = r;
        out_d   = filter_out;
        ce_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start_q) begin
                    x_d     = snap;
                    k_d     = '0;
                    state_d = COMB;
                end
            end
            COMB: begin
                // Each comb stage delays its own input by one decimated sample
                x_d     = x - cd[k];
                cd_d[k] = x;
                k_d     = k + K_W'(1);
                if (k == K_W'(N - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                r_d     = rnd_c;
                state_d = OUT;
            end
            OUT: begin
                out_d   = r;
                ce_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            k          <= '0;
            r          <= '0;
            filter_out <= '0;
            ce_out     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cd[i] <= '0;
            end
        end else begin
            x          <= x_d;
            k          <= k_d;
            r          <= r_d;
            filter_out <= out_d;
            ce_out     <= ce_d;
            cd         <= cd_d;
        end
    end

    // R >= N+3 guarantees the comb sequence finishes before the next snapshot
    a_start_in_idle: assert property (
        @(posedge clk) disable iff (reset) start_q |-> (state == IDLE)
    );

endmodule

// File: rtl/cic_decim_front.sv
// Hogenauer CIC decimator feeding the 2:1 compensation FIR: pipelined integrator
// bank and decimation counter here, time-multiplexed combs in cic_comb_engine.
module cic_decim_front
    import cic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cic_decim_front_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(R);

    logic signed [ACC_W-1:0] integ [N];
    logic [CNT_W-1:0]        dcnt;
    logic signed [ACC_W-1:0] sample_ext_c;
    logic signed [ACC_W-1:0] snap_c;
    logic                    start_c;

    assign sample_ext_c = {{(ACC_W - DW_IN){bus.filter_in[DW_IN-1]}}, bus.filter_in};
    assign start_c      = bus.in_valid && (dcnt == CNT_W'(R - 1));
    // Value the last integrator takes on this edge, i.e. including this sample
    assign snap_c       = integ[N-1] + integ[N-2];

    // Integrators wrap modulo 2^ACC_W; the combs recover the exact result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
            for (int i = 0; i < N; i++) begin
                integ[i] <= '0;
            end
        end else if (bus.in_valid) begin
            integ[0] <= integ[0] + sample_ext_c;
            for (int i = 1; i < N; i++) begin
                integ[i] <= integ[i] + integ[i-1];
            end
            dcnt <= (dcnt == CNT_W'(R - 1)) ? '0 : dcnt + CNT_W'(1);
        end
    end

    cic_comb_engine u_comb (
        .clk        (clk),
        .reset      (reset),
        .start_c    (start_c),
        .snap_c     (snap_c),
        .filter_out (bus.filter_out),
        .ce_out     (bus.ce_out)
    );

endmodule

// File: tb/tb_cic_decim_front.sv
// Scoreboard bench for cic_decim_front: blocks of R samples at constant level,
// expected outputs from a closed-form block-rate CIC model.
module tb_cic_decim_front;
    import cic_pkg::*;

    // Drive negedge of the decimating sample to the negedge where ce_out is seen
    localparam longint CE_LAT = 8;

    typedef struct {
        longint value;
        longint due;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    exp_t   sb_q[$];
    logic signed [DW_OUT-1:0] hold = '0;
    longint hist [4];
    longint h    [4];

    cic_decim_front_if bus ();

    cic_decim_front dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // C(t,4): fourth integrator value t samples after a unit step
    function automatic longint b4(input longint t);
        if (t <= 0) return 0;
        return (t * (t - 1) * (t - 2) * (t - 3)) / 24;
    endfunction

    // Unit-step response after m decimated outputs (full precision)
    function automatic longint g(input int m);
        longint rl;
        longint t;
        rl = longint'(R);
        t  = longint'(m) * rl;
        return b4(t) - 4 * b4(t - rl) + 6 * b4(t - 2 * rl) - 4 * b4(t - 3 * rl) + b4(t - 4 * rl);
    endfunction

    function automatic longint expect_out();
        longint full;
        full = 0;
        for (int j = 0; j < 4; j++) full += h[j] * hist[j];
        full = (full + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (full > 2047) full = 2047;
        else if (full < -2048) full = -2048;
        return full;
    endfunction

    // One decimation block of R valid samples; gap idle cycles after each sample
    task automatic drive_block(input int level, input int gap);
        exp_t e;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'(level);
        for (int s = 0; s < int'(R); s++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.filter_in = DW_IN'(level);
            if (s == int'(R) - 1) begin
                e.value = expect_out();
                e.due   = cyc + CE_LAT;
                sb_q.push_back(e);
            end
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset == 1'b0) begin
            if (bus.ce_out) begin
                if (sb_q.size() == 0) begin
                    check("unexpected ce_out", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("ce_out timing", cyc, e.due);
                    check("filter_out", longint'(bus.filter_out), e.value);
                    hold = DW_OUT'(e.value);
                end
            end else begin
                check("held filter_out", longint'(bus.filter_out), longint'(hold));
                if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                    check("missing ce_out", 0, 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.filter_in = '0;
        for (int j = 0; j < 4; j++) begin
            hist[j] = 0;
            h[j]    = g(j + 1) - g(j);
        end

        repeat (3) @(negedge clk);
        check("reset filter_out", longint'(bus.filter_out), 0);
        check("reset ce_out", longint'(bus.ce_out), 0);
        reset = 1'b0;

        repeat (3) drive_block(0, 0);
        repeat (6) drive_block(1000, 0);
        repeat (8) drive_block(32767, 0);
        repeat (8) drive_block(-32768, 0);
        repeat (6) drive_block(1000, 2);

        // Reset while the comb sequence is running: that output must never appear
        drive_block(1000, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        hold = '0;
        for (int j = 0; j < 4; j++) hist[j] = 0;
        #1;
        check("mid-comb reset filter_out", longint'(bus.filter_out), 0);
        check("mid-comb reset ce_out", longint'(bus.ce_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        repeat (6) drive_block(1000, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;

        repeat (20) @(negedge clk);
        while (sb_q.size() != 0) begin
            check("missing ce_out at end", 0, 1);
            void'(sb_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_decim_front.md
Name: cic_decim_front

Overview:
- Hogenauer CIC decimator (N integrators, decimate by R, N combs, differential delay M=1).
- Sits directly upstream of the 2:1 polyphase CIC-compensation FIR.
- Converts the fast ADC-side sample stream to the 40 kHz, 12-bit stream plus one-cycle strobe consumed by that FIR.
- Combs are time-multiplexed onto one subtractor by a small FSM.

Parameters:
- DW_IN, 16, input sample width, signed
- DW_OUT, 12, output width, signed; matches compensation FIR DW_IN
- N, 4, number of integrator and comb stages
- R, 625, decimation ratio; must satisfy R >= N+3
- ACC_W, 54, internal width; must be >= DW_IN + ceil(N*log2(R))
- SHIFT, ACC_W-DW_OUT (42), localparam; LSBs discarded at output

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample strobe; may be high every cycle
- filter_in  in  DW_IN  signed input sample, sampled when in_valid=1
- filter_out  out  DW_OUT  signed decimated sample, held between strobes
- ce_out  out  1  one-cycle pulse when filter_out updates; drives the FIR clk_enable

Behaviour:
- Reset (async): all integrators, comb delay registers, snapshot, decimation counter and FSM are cleared; filter_out=0, ce_out=0.
- Integrators (pipelined Hogenauer form), on in_valid only:
  - i1 <= i1 + sext(filter_in)
  - ik <= ik + i(k-1) (old value), for k=2..N
  - Pure modulo-2^ACC_W two's-complement wrap; no saturation anywhere in integrators or combs.
- Decimation counter dcnt, 0..R-1:
  - Increments on in_valid and wraps to 0.
  - When in_valid and dcnt==R-1: snap <= updated iN value (iN + i(N-1)), and the FSM starts.
- FSM states IDLE, COMB, ROUND, OUT:
  - IDLE: x <= snap on start; go to COMB with k=0.
  - COMB: one stage per cycle.
    - x <= x - cd[k]; cd[k] <= x (pre-subtract value); k++.
    - After k=N-1, go to ROUND.
  - ROUND: r = (x + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up (floor(v+0.5)).
    - If the rounding add carries into positive overflow, saturate to +2^(DW_OUT-1)-1.
    - Negative saturation cannot occur, but implement it symmetrically.
  - OUT: filter_out <= r; ce_out=1 for exactly this cycle; go to IDLE.
- Latency: the decimating in_valid edge to ce_out is N+3 clk cycles, fixed.
- ce_out period is exactly R in_valid pulses; filter_out is stable for all non-ce_out cycles.
- Integrators keep running during the comb FSM. A new start while not in IDLE cannot occur, because R >= N+3 with in_valid at most once per cycle.
  - Add a simulation assertion that start is never asserted outside IDLE.
- in_valid=0: integrators and counter hold; the FSM still completes if already running.
- Reset mid-FSM: aborts the sequence, no ce_out is emitted, and the first output after reset release comes R valid samples later.
- Arithmetic width: DC gain = R^N / 2^SHIFT = 0.0346944 at defaults; DC x maps to round(0.0346944*x).

Decomposition:
- cic_pkg holds: N, R, ACC_W, SHIFT, ROUND_K=2^(SHIFT-1), OUT_MAX/OUT_MIN constants, and the FSM state enum (2 bits).
- One sub-module, cic_comb_engine: snapshot-in / start, the N-entry comb delay array, the time-multiplexed subtractor, round/saturate, and output register with ce_out.
- The integrator bank and decimation counter stay in the top level.

Test Plan:
- Reset, then in_valid every cycle, filter_in=0 -> filter_out=0 always; ce_out exactly every 625 cycles; first ce_out 625+N+3-1=631 cycles after the first in_valid.
- DC filter_in=1000, in_valid every cycle -> from the 6th ce_out onward filter_out=35, constant.
- DC filter_in=32767 for 2000 outputs (integrators wrap repeatedly) -> settled filter_out=1137 every output, no glitch. DC -32768 -> settled filter_out=-1137.
- in_valid every 3rd cycle, DC 1000 -> ce_out spacing 1875 cycles; settled value 35; filter_out unchanged between strobes.
- Assert reset 2 cycles after a decimating in_valid (mid-COMB) -> no ce_out; filter_out=0 immediately. Restart with DC 1000 -> first ce_out after 625 valids + N+2 cycles, converging to 35.
- Step from 0 to 1000 -> monotone rise over outputs 1..5, reaching 35 by output 5. Compare every output bit-exactly against the Python reference model.
